// File: rtl/vga_pattern_ctrl_if.sv
// Video output bundle of the VGA pattern controller: pattern controls in, timing and colour out.
// The master side is the pattern generator; the slave side is the display sink or its driver.
interface vga_pattern_ctrl_if #(
    parameter int CW = 4
);
    logic [2:0]      mode;
    logic [3*CW-1:0] solid_rgb;
    logic            vga_hsync;
    logic            vga_vsync;
    logic            vga_valid;
    logic [9:0]      h_addr;
    logic [9:0]      v_addr;
    logic [CW-1:0]   vga_red;
    logic [CW-1:0]   vga_green;
    logic [CW-1:0]   vga_blue;
    logic            frame_start;
    logic [15:0]     frame_cnt;

    modport master (
        input  mode, solid_rgb,
        output vga_hsync, vga_vsync, vga_valid, h_addr, v_addr,
        output vga_red, vga_green, vga_blue, frame_start, frame_cnt
    );

    modport slave (
        output mode, solid_rgb,
        input  vga_hsync, vga_vsync, vga_valid, h_addr, v_addr,
        input  vga_red, vga_green, vga_blue, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_pattern_ctrl.sv
// Parametrised VGA timing generator with a frame-synchronous test-pattern engine.
// Every output is registered one clock after the raster counter state it describes.
module vga_pattern_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 4,
    parameter int SYNC_POL = 0,
    parameter int BOX      = 32
) (
    input  logic                clk,
    input  logic                rst,
    vga_pattern_ctrl_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BX_MAX   = 10'(H_ACTIVE - BOX);
    localparam logic [9:0] BY_MAX   = 10'(V_ACTIVE - BOX);
    localparam logic [10:0] BOX_LEN = 11'(BOX);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);
    localparam logic [9:0] B1 = 10'(1 * H_ACTIVE / 8);
    localparam logic [9:0] B2 = 10'(2 * H_ACTIVE / 8);
    localparam logic [9:0] B3 = 10'(3 * H_ACTIVE / 8);
    localparam logic [9:0] B4 = 10'(4 * H_ACTIVE / 8);
    localparam logic [9:0] B5 = 10'(5 * H_ACTIVE / 8);
    localparam logic [9:0] B6 = 10'(6 * H_ACTIVE / 8);
    localparam logic [9:0] B7 = 10'(7 * H_ACTIVE / 8);

    function automatic logic [2:0] bar_index(input logic [9:0] x);
        logic [2:0] k;
        if (x < B1)      k = 3'd0;
        else if (x < B2) k = 3'd1;
        else if (x < B3) k = 3'd2;
        else if (x < B4) k = 3'd3;
        else if (x < B5) k = 3'd4;
        else if (x < B6) k = 3'd5;
        else if (x < B7) k = 3'd6;
        else             k = 3'd7;
        return k;
    endfunction

    // One bit per channel {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_colour(input logic [2:0] k);
        logic [2:0] c;
        case (k)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // Returns {dir_neg, pos}; the box reverses on the step after it touches a limit.
    function automatic logic [10:0] box_step(input logic [9:0] pos, input logic neg,
                                             input logic [9:0] lim);
        logic [10:0] r;
        if (lim == 10'd0) begin
            r = {neg, pos};
        end else if (!neg) begin
            if (pos == lim) r = {1'b1, pos - 10'd1};
            else            r = {1'b0, pos + 10'd1};
        end else begin
            if (pos == 10'd0) r = {1'b0, 10'd1};
            else              r = {1'b1, pos - 10'd1};
        end
        return r;
    endfunction

    logic [9:0]      h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [2:0]      mode_q, mode_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [9:0]      bx_q, bx_d, by_q, by_d;
    logic            dx_q, dx_d, dy_q, dy_d;
    logic            hsync_q, hsync_d, vsync_q, vsync_d, valid_q, valid_d;
    logic [9:0]      h_addr_q, h_addr_d, v_addr_q, v_addr_d;
    logic [CW-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic            fs_q, fs_d;
    logic            eol_s, eof_s, active_s, in_box_s;
    logic [2:0]      col_s;
    logic [10:0]     bx_step_s, by_step_s;
    logic [3*CW-1:0] rgb_s;

    // Raster counters, frame-boundary mode latch, frame counter and box motion.
    always_comb begin
        eol_s       = (h_cnt_q == H_LAST);
        eof_s       = eol_s && (v_cnt_q == V_LAST);
        bx_step_s   = box_step(bx_q, dx_q, BX_MAX);
        by_step_s   = box_step(by_q, dy_q, BY_MAX);
        h_cnt_d     = h_cnt_q + 10'd1;
        v_cnt_d     = v_cnt_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        if (eol_s) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == V_LAST) v_cnt_d = 10'd0;
            else                   v_cnt_d = v_cnt_q + 10'd1;
        end else begin
            v_cnt_d = v_cnt_q;
        end
        if (eof_s) begin
            mode_d      = vga.mode;
            frame_cnt_d = frame_cnt_q + 16'd1;
            {dx_d, bx_d} = bx_step_s;
            {dy_d, by_d} = by_step_s;
        end else begin
            mode_d = mode_q;
        end
    end

    // Pattern colour for the current counter position, black outside active video.
    always_comb begin
        active_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        col_s    = bar_colour(bar_index(h_cnt_q));
        in_box_s = ({1'b0, h_cnt_q} >= {1'b0, bx_q}) && ({1'b0, h_cnt_q} < {1'b0, bx_q} + BOX_LEN) &&
                   ({1'b0, v_cnt_q} >= {1'b0, by_q}) && ({1'b0, v_cnt_q} < {1'b0, by_q} + BOX_LEN);
        rgb_s    = {(3*CW){1'b0}};
        if (active_s) begin
            case (mode_q)
                3'd0: rgb_s = vga.solid_rgb;
                3'd1: rgb_s = {{CW{col_s[2]}}, {CW{col_s[1]}}, {CW{col_s[0]}}};
                3'd2: rgb_s = (h_cnt_q[5] ^ v_cnt_q[5]) ? {(3*CW){1'b0}} : {(3*CW){1'b1}};
                3'd3: rgb_s = {h_cnt_q[CW+3:4], v_cnt_q[CW+3:4], h_cnt_q[CW+3:4] ^ v_cnt_q[CW+3:4]};
                3'd4: rgb_s = in_box_s ? vga.solid_rgb : {(3*CW){1'b0}};
                default: rgb_s = {(3*CW){1'b0}};
            endcase
        end else begin
            rgb_s = {(3*CW){1'b0}};
        end
    end

    // Next values of the registered video outputs.
    always_comb begin
        hsync_d  = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d  = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_ON : ~SYNC_ON;
        valid_d  = active_s;
        h_addr_d = active_s ? h_cnt_q : 10'd0;
        v_addr_d = active_s ? v_cnt_q : 10'd0;
        red_d    = rgb_s[3*CW-1:2*CW];
        green_d  = rgb_s[2*CW-1:CW];
        blue_d   = rgb_s[CW-1:0];
        fs_d     = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            mode_q      <= 3'd0;
            frame_cnt_q <= 16'd0;
            bx_q        <= 10'd0;
            by_q        <= 10'd0;
            dx_q        <= 1'b0;
            dy_q        <= 1'b0;
            hsync_q     <= ~SYNC_ON;
            vsync_q     <= ~SYNC_ON;
            valid_q     <= 1'b0;
            h_addr_q    <= 10'd0;
            v_addr_q    <= 10'd0;
            red_q       <= {CW{1'b0}};
            green_q     <= {CW{1'b0}};
            blue_q      <= {CW{1'b0}};
            fs_q        <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            valid_q     <= valid_d;
            h_addr_q    <= h_addr_d;
            v_addr_q    <= v_addr_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            fs_q        <= fs_d;
        end
    end

    assign vga.vga_hsync   = hsync_q;
    assign vga.vga_vsync   = vsync_q;
    assign vga.vga_valid   = valid_q;
    assign vga.h_addr      = h_addr_q;
    assign vga.v_addr      = v_addr_q;
    assign vga.vga_red     = red_q;
    assign vga.vga_green   = green_q;
    assign vga.vga_blue    = blue_q;
    assign vga.frame_start = fs_q;
    assign vga.frame_cnt   = frame_cnt_q;

endmodule
